// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute bundle for decode_stage.
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are high. The source holds valid and its payload steady until that
// edge. The sink may raise or lower ready at any time. Ready never depends
// combinationally on valid.
interface decode_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_ra;
   logic [4:0]      out_rb;
   logic [4:0]      out_rd;
   logic [1:0]      out_alu_op;
   logic [1:0]      out_alu2_op;
   logic            out_alt_op;
   logic            out_alt2_op;
   logic            out_sel_pc_a;
   logic            out_sel_imm_b;
   logic [1:0]      out_wb;
   logic            out_mem;
   logic            out_mem_read;
   logic            out_branch;
   logic [2:0]      out_comparison;
   logic            out_muldiv;
   logic            out_illegal;

   // Fetch / execute side.
   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_ra, out_rb, out_rd,
             out_alu_op, out_alu2_op, out_alt_op, out_alt2_op,
             out_sel_pc_a, out_sel_imm_b, out_wb, out_mem, out_mem_read,
             out_branch, out_comparison, out_muldiv, out_illegal
   );

   // Decode stage side.
   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_ra, out_rb, out_rd,
             out_alu_op, out_alu2_op, out_alt_op, out_alt2_op,
             out_sel_pc_a, out_sel_imm_b, out_wb, out_mem, out_mem_read,
             out_branch, out_comparison, out_muldiv, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: DEPTH-entry instruction queue feeding a single
// registered decoded bundle with back-pressure, flush and illegal flagging.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int EN_M  = 1
) (
   input logic     clk,
   input logic     rst,
   decode_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [4:0]      ra;
      logic [4:0]      rb;
      logic [4:0]      rd;
      logic [1:0]      alu_op;
      logic [1:0]      alu2_op;
      logic            alt_op;
      logic            alt2_op;
      logic            sel_pc_a;
      logic            sel_imm_b;
      logic [1:0]      wb;
      logic            mem;
      logic            mem_read;
      logic            branch;
      logic [2:0]      comparison;
      logic            muldiv;
      logic            illegal;
   } bundle_t;

   logic [31:0]     q_instr [DEPTH];
   logic [XLEN-1:0] q_pc    [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;

   bundle_t         dec;
   bundle_t         out_q;
   logic [XLEN-1:0] out_pc_q;
   logic            out_valid_q;

   logic            push;
   logic            pop;
   logic [31:0]     head;

   assign bus.in_ready = !rst && (count != FULL);
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = (count != '0) && (!out_valid_q || bus.out_ready);
   assign head = q_instr[rd_ptr];

   // Decode the queue head into a full control bundle.
   always_comb begin
      logic [4:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        sd;
      logic        op_ok;
      logic        f7_ok;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

      op = head[6:2];
      f3 = head[14:12];
      f7 = head[31:25];
      sd = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3) || (f3 == 3'd5);

      imm_i = {{20{head[31]}}, head[31:20]};
      imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
      imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      imm_u = {head[31:12], 12'b0};
      imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};

      dec          = '0;
      dec.ra       = head[19:15];
      dec.rb       = head[24:20];
      dec.rd       = head[11:7];
      dec.mem      = !head[6] && !head[4] && !head[3] && !head[2];
      dec.mem_read = !head[5];

      if (op[1]) begin
         dec.imm       = XLEN'($signed(imm_j));
         dec.sel_imm_b = 1'b1;
         dec.sel_pc_a  = 1'b1;
         dec.branch    = 1'b1;
         dec.wb        = 2'd1;
         dec.mem       = 1'b0;
         dec.mem_read  = 1'b0;
      end else if (op[2] && op[0]) begin
         dec.imm       = XLEN'($signed(imm_u));
         dec.alu2_op   = 2'd3;
         dec.sel_pc_a  = 1'b1;
         dec.sel_imm_b = !head[5];
         dec.wb        = {1'b1, head[5]};
      end else if (!op[4] && op[3] && op[2]) begin
         if ((EN_M != 0) && (f7 == 7'h01)) begin
            dec.muldiv     = 1'b1;
            dec.comparison = f3;
            dec.wb         = 2'd3;
         end else begin
            dec.alu_op    = {f3[2], f3[1] ^ f3[0]};
            dec.alu2_op   = {f3[2], f3[1]};
            dec.alt_op    = (f7 == 7'h20);
            dec.alt2_op   = (f7 == 7'h20);
            dec.sel_imm_b = sd;
            dec.wb        = {1'b1, sd};
         end
      end else if (!op[4] && op[3]) begin
         dec.imm       = XLEN'($signed(imm_s));
         dec.sel_imm_b = 1'b1;
      end else if (op[4] && !op[2] && !op[1] && !op[0]) begin
         dec.imm        = XLEN'($signed(imm_b));
         dec.alu2_op    = 2'd1;
         dec.sel_imm_b  = 1'b1;
         dec.sel_pc_a   = 1'b1;
         dec.branch     = 1'b1;
         dec.comparison = f3;
      end else begin
         dec.imm       = XLEN'($signed(imm_i));
         dec.alu_op    = {f3[2], f3[1] ^ f3[0]};
         dec.alu2_op   = {f3[2], f3[1]};
         dec.alt2_op   = head[30];
         dec.sel_imm_b = !sd;
         dec.wb        = {1'b1, sd};
      end

      // x0 is never written back.
      if (dec.rd == 5'd0) dec.wb = 2'd0;

      case (head[6:0])
         7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: op_ok = 1'b1;
         default:                           op_ok = 1'b0;
      endcase
      f7_ok = (f7 == 7'h00) || (f7 == 7'h20) || ((EN_M != 0) && (f7 == 7'h01));

      // Illegal bundles still flow so execute can trap, but with no side effects.
      if ((head[1:0] != 2'b11) || !op_ok || ((head[6:0] == 7'h33) && !f7_ok)) begin
         dec.illegal = 1'b1;
         dec.wb      = 2'd0;
         dec.mem     = 1'b0;
         dec.branch  = 1'b0;
         dec.muldiv  = 1'b0;
      end
   end

   // Queue storage; entries are only written, never cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr] <= bus.in_instr;
         q_pc[wr_ptr]    <= bus.in_pc;
      end
   end

   // Queue pointers and occupancy; flush wins over push and pop.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // Output register: load the decoded head, or drain once execute takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         out_pc_q    <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         out_q       <= dec;
         out_pc_q    <= q_pc[rd_ptr];
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.out_pc         = out_pc_q;
   assign bus.out_imm        = out_q.imm;
   assign bus.out_ra         = out_q.ra;
   assign bus.out_rb         = out_q.rb;
   assign bus.out_rd         = out_q.rd;
   assign bus.out_alu_op     = out_q.alu_op;
   assign bus.out_alu2_op    = out_q.alu2_op;
   assign bus.out_alt_op     = out_q.alt_op;
   assign bus.out_alt2_op    = out_q.alt2_op;
   assign bus.out_sel_pc_a   = out_q.sel_pc_a;
   assign bus.out_sel_imm_b  = out_q.sel_imm_b;
   assign bus.out_wb         = out_q.wb;
   assign bus.out_mem        = out_q.mem;
   assign bus.out_mem_read   = out_q.mem_read;
   assign bus.out_branch     = out_q.branch;
   assign bus.out_comparison = out_q.comparison;
   assign bus.out_muldiv     = out_q.muldiv;
   assign bus.out_illegal    = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit instance with the M extension
// and a 64-bit instance without it, both fed the same instruction stream.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;

   decode_if #(.XLEN(32)) bus_a ();
   decode_if #(.XLEN(64)) bus_b ();

   decode_stage #(.XLEN(32), .DEPTH(4), .EN_M(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   decode_stage #(.XLEN(64), .DEPTH(4), .EN_M(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_imm_q[$];

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
      bus_a.in_valid = valid;
      bus_b.in_valid = valid;
      bus_a.in_instr = instr;
      bus_b.in_instr = instr;
      bus_a.in_pc    = pc;
      bus_b.in_pc    = {32'h0, pc};
   endtask

   task automatic set_ready(input logic r);
      bus_a.out_ready = r;
      bus_b.out_ready = r;
   endtask

   task automatic set_flush(input logic f);
      bus_a.flush = f;
      bus_b.flush = f;
   endtask

   // Push one instruction into an idle stage and wait for its bundle.
   task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
      drive(1'b1, instr, pc);
      step();
      drive(1'b0, 32'h0, 32'h0);
      step();
   endtask

   initial begin
      int accepted;
      logic ready_pre;
      logic [31:0] e_pc;
      logic [31:0] e_imm;

      drive(1'b0, 32'h0, 32'h0);
      set_flush(1'b0);
      set_ready(1'b1);
      rst = 1'b1;
      step();
      step();

      // Reset state.
      check("rst_out_valid", bus_a.out_valid, 64'd0);
      check("rst_in_ready",  bus_a.in_ready,  64'd0);
      check("rst_out_imm",   bus_a.out_imm,   64'd0);
      check("rst_out_wb",    bus_a.out_wb,    64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", bus_a.in_ready, 64'd1);

      // ADDI x1,x0,5 with latency check.
      drive(1'b1, 32'h00500093, 32'h100);
      step();
      drive(1'b0, 32'h0, 32'h0);
      check("addi_not_yet_valid", bus_a.out_valid, 64'd0);
      step();
      check("addi_valid",     bus_a.out_valid,     64'd1);
      check("addi_pc",        bus_a.out_pc,        64'h100);
      check("addi_imm",       bus_a.out_imm,       64'd5);
      check("addi_alu_op",    bus_a.out_alu_op,    64'd0);
      check("addi_sel_imm_b", bus_a.out_sel_imm_b, 64'd1);
      check("addi_wb",        bus_a.out_wb,        64'd2);
      check("addi_illegal",   bus_a.out_illegal,   64'd0);
      check("addi_rd",        bus_a.out_rd,        64'd1);

      // JAL x1,+8 on the 64-bit instance.
      send_one(32'h008000EF, 32'h104);
      check("jal_imm",      bus_b.out_imm,      64'h8);
      check("jal_branch",   bus_b.out_branch,   64'd1);
      check("jal_sel_pc_a", bus_b.out_sel_pc_a, 64'd1);
      check("jal_wb",       bus_b.out_wb,       64'd1);

      // LUI x2,0x80000 sign-extends on both widths.
      send_one(32'h80000137, 32'h108);
      check("lui_imm64", bus_b.out_imm, 64'hFFFF_FFFF_8000_0000);
      check("lui_wb64",  bus_b.out_wb,  64'd3);
      check("lui_imm32", bus_a.out_imm, 64'h8000_0000);

      // ADDI x5,x0,-1: all-ones immediate.
      send_one(32'hFFF00293, 32'h10C);
      check("addi_neg_imm32", bus_a.out_imm, 64'hFFFF_FFFF);
      check("addi_neg_imm64", bus_b.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

      // SW x2,8(x1).
      send_one(32'h0020A423, 32'h110);
      check("sw_imm",      bus_a.out_imm,      64'd8);
      check("sw_mem",      bus_a.out_mem,      64'd1);
      check("sw_mem_read", bus_a.out_mem_read, 64'd0);
      check("sw_wb",       bus_a.out_wb,       64'd0);

      // BEQ x1,x2,+8.
      send_one(32'h00208463, 32'h114);
      check("beq_imm",        bus_a.out_imm,        64'd8);
      check("beq_branch",     bus_a.out_branch,     64'd1);
      check("beq_sel_pc_a",   bus_a.out_sel_pc_a,   64'd1);
      check("beq_alu2_op",    bus_a.out_alu2_op,    64'd1);
      check("beq_comparison", bus_a.out_comparison, 64'd0);
      check("beq_wb",         bus_a.out_wb,         64'd0);

      // MUL x3,x1,x2: mul/div with EN_M, illegal without.
      send_one(32'h022081B3, 32'h118);
      check("mul_muldiv",     bus_a.out_muldiv,     64'd1);
      check("mul_comparison", bus_a.out_comparison, 64'd0);
      check("mul_wb",         bus_a.out_wb,         64'd3);
      check("mul_illegal",    bus_a.out_illegal,    64'd0);
      check("mul_nom_illegal", bus_b.out_illegal,   64'd1);
      check("mul_nom_wb",      bus_b.out_wb,        64'd0);
      check("mul_nom_muldiv",  bus_b.out_muldiv,    64'd0);

      // All-zero word is illegal with no side effects.
      send_one(32'h00000000, 32'h11C);
      check("zero_illegal", bus_a.out_illegal, 64'd1);
      check("zero_mem",     bus_a.out_mem,     64'd0);
      check("zero_wb",      bus_a.out_wb,      64'd0);
      check("zero_valid",   bus_a.out_valid,   64'd1);
      step();
      check("drain_valid", bus_a.out_valid, 64'd0);

      // Capacity: DEPTH+1 accepted while execute stalls.
      set_ready(1'b0);
      accepted = 0;
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 32'h00000093 | (32'(accepted) << 20), 32'h200 + 32'(accepted) * 4);
         ready_pre = bus_a.in_ready;
         step();
         if (ready_pre) accepted++;
      end
      drive(1'b0, 32'h0, 32'h0);
      check("cap_accepted", 64'(accepted), 64'd5);
      check("cap_in_ready", bus_a.in_ready, 64'd0);
      check("cap_hold_pc",  bus_a.out_pc,   64'h200);
      step();
      check("cap_hold_pc2", bus_a.out_pc,   64'h200);
      check("cap_hold_imm", bus_a.out_imm,  64'd0);
      set_ready(1'b1);
      for (int i = 0; i < 5; i++) begin
         check("cap_valid", bus_a.out_valid, 64'd1);
         check("cap_pc",    bus_a.out_pc,    64'h200 + 64'(i) * 4);
         check("cap_imm",   bus_a.out_imm,   64'(i));
         step();
      end
      check("cap_empty", bus_a.out_valid, 64'd0);

      // Flush with three in flight and a same-cycle push.
      set_ready(1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h00100093, 32'h300 + 32'(i) * 4);
         step();
      end
      drive(1'b1, 32'h00700093, 32'h30C);
      set_flush(1'b1);
      step();
      set_flush(1'b0);
      drive(1'b0, 32'h0, 32'h0);
      check("flush_valid",    bus_a.out_valid, 64'd0);
      check("flush_in_ready", bus_a.in_ready,  64'd1);
      set_ready(1'b1);
      step();
      check("flush_dropped", bus_a.out_valid, 64'd0);
      step();
      check("flush_dropped2", bus_a.out_valid, 64'd0);
      send_one(32'h00900093, 32'h400);
      check("post_flush_pc",  bus_a.out_pc,  64'h400);
      check("post_flush_imm", bus_a.out_imm, 64'd9);

      // 20 back-to-back pushes crossing the pointer wrap at full rate.
      for (int i = 0; i < 21; i++) begin
         if (i < 20) begin
            drive(1'b1, 32'h00000093 | (32'(i) << 20), 32'h1000 + 32'(i) * 4);
            exp_q.push_back(32'h1000 + 32'(i) * 4);
            exp_imm_q.push_back(32'(i));
         end else begin
            drive(1'b0, 32'h0, 32'h0);
         end
         step();
         if (i > 0) begin
            e_pc  = exp_q.pop_front();
            e_imm = exp_imm_q.pop_front();
            check("wrap_valid", bus_a.out_valid, 64'd1);
            check("wrap_pc",    bus_a.out_pc,    64'(e_pc));
            check("wrap_imm",   bus_a.out_imm,   64'(e_imm));
         end
      end
      check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset mid-stream discards everything.
      set_ready(1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hFFF00293, 32'h500 + 32'(i) * 4);
         step();
      end
      drive(1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      step();
      check("mrst_valid",    bus_a.out_valid, 64'd0);
      check("mrst_pc",       bus_a.out_pc,    64'd0);
      check("mrst_imm",      bus_a.out_imm,   64'd0);
      check("mrst_wb",       bus_a.out_wb,    64'd0);
      check("mrst_rd",       bus_a.out_rd,    64'd0);
      check("mrst_in_ready", bus_a.in_ready,  64'd0);
      rst = 1'b0;
      set_ready(1'b1);
      step();
      check("mrst_ready_after", bus_a.in_ready,  64'd1);
      check("mrst_empty_after", bus_a.out_valid, 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
